io_port_unit: RTL

- Memory-mapped I/O responder that sits between the pipelined CPU's data-memory I/O region and the board-level switches, LEDs and 7-segment displays.
- The CPU drives it: stores go to the output and display registers, loads return the input-port values.
- Input ports are synchronized and debounced before the CPU can see them.
- Display writes are converted to decimal by a sequential binary-to-BCD engine and driven onto six active-low 7-segment outputs.

---
 rtl/io_pkg.sv | 43 ++++
 rtl/bin2bcd_seq.sv | 89 ++++++++
 rtl/io_port_unit.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/io_pkg.sv
// Shared definitions for the memory-mapped I/O port unit.
//   - Address offsets (addr[7:0]) of every register the CPU can reach.
//   - Display FSM state encoding.
//   - 7-segment constants and the BCD-to-segment lookup.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package io_pkg;

  localparam logic [7:0] ADDR_OUT0 = 8'h80;
  localparam logic [7:0] ADDR_OUT1 = 8'h84;
  localparam logic [7:0] ADDR_DISP = 8'h88;
  localparam logic [7:0] ADDR_STAT = 8'h8C;
  localparam logic [7:0] ADDR_IN0  = 8'hC0;
  localparam logic [7:0] ADDR_IN1  = 8'hC4;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } disp_state_e;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock).
// Ports:
//   clock, resetn : system clock, asynchronous active-low reset
//   start         : load `value` on this edge and begin converting
//   value         : binary input, DISP_W bits
//   busy          : iterations in progress
//   done          : high during the cycle whose closing edge performs the
//                   last iteration; bcd is final right after that edge
//   bcd           : six BCD digits, digit 0 in bcd[3:0]
module bin2bcd_seq
  import io_pkg::*;
#(
  parameter int DISP_W = 20
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic [DISP_W-1:0] value,
  output logic              busy,
  output logic              done,
  output logic [23:0]       bcd
);

  // Every 3 binary bits need at most one decimal digit; keep at least the
  // six digits that are exported.
  localparam int NDIG_RAW = (DISP_W + 2) / 3;
  localparam int NDIG     = (NDIG_RAW < 6) ? 6 : NDIG_RAW;
  localparam int BCD_W    = 4 * NDIG;
  localparam int CNT_W    = (DISP_W > 1) ? $clog2(DISP_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DISP_W - 1);

  logic [DISP_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d, adj;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;

  // Add 3 to every digit that is 5 or more before the next left shift.
  genvar gi;
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_adj
      assign adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? (bcd_q[4*gi +: 4] + 4'd3)
                                                         : bcd_q[4*gi +: 4];
    end
  endgenerate

  always_comb begin
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start) begin
      bin_d  = value;
      bcd_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      bcd_d = {adj[BCD_W-2:0], bin_q[DISP_W-1]};
      bin_d = bin_q << 1;
      if (cnt_q == CNT_LAST) begin
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == CNT_LAST);
  assign bcd  = bcd_q[23:0];

  // The top digit's carry-out cannot occur for in-range values.
  logic unused_adj_msb;
  assign unused_adj_msb = adj[BCD_W-1];

endmodule

// File: rtl/io_port_unit.sv
// Memory-mapped I/O responder between the CPU data bus and board I/O.
// Ports:
//   clock, resetn       : system clock, asynchronous active-low reset
//   addr, we, wdata     : CPU store/load interface (addr[7:2] decoded)
//   rdata               : combinational load data
//   in_port0/1          : raw asynchronous switch banks (synced + debounced)
//   out_port0/1         : output registers
//   hex0..hex5          : active-low 7-segment digits, hex0 least significant
//   disp_busy           : display conversion in progress
module io_port_unit
  import io_pkg::*;
#(
  parameter int PORT_W          = 10,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DISP_W          = 20
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [31:0]       addr,
  input  logic              we,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  input  logic [PORT_W-1:0] in_port0,
  input  logic [PORT_W-1:0] in_port1,
  output logic [PORT_W-1:0] out_port0,
  output logic [PORT_W-1:0] out_port1,
  output logic [6:0]        hex0,
  output logic [6:0]        hex1,
  output logic [6:0]        hex2,
  output logic [6:0]        hex3,
  output logic [6:0]        hex4,
  output logic [6:0]        hex5,
  output logic              disp_busy
);

  localparam int DB_CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_CW-1:0] DB_LAST = DB_CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [63:0] DISP_MAX = 64'd999999;

  // ---------------- input synchronizer + debouncer, one per bank ----------------
  logic [1:0][PORT_W-1:0] in_raw, in_deb;
  assign in_raw = {in_port1, in_port0};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_deb
      logic [PORT_W-1:0] sync1_q, sync2_q;
      logic [PORT_W-1:0] cand_q, cand_d, deb_q, deb_d;
      logic [DB_CW-1:0]  cnt_q, cnt_d;

      // Any difference restarts the stability count, so a glitch shorter
      // than the full count is simply forgotten.
      always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        deb_d  = deb_q;
        if (sync2_q != cand_q) begin
          cand_d = sync2_q;
          cnt_d  = '0;
        end else if (cnt_q == DB_LAST) begin
          deb_d = cand_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
          sync1_q <= '0;
          sync2_q <= '0;
          cand_q  <= '0;
          cnt_q   <= '0;
          deb_q   <= '0;
        end else begin
          sync1_q <= in_raw[gi];
          sync2_q <= sync1_q;
          cand_q  <= cand_d;
          cnt_q   <= cnt_d;
          deb_q   <= deb_d;
        end
      end

      assign in_deb[gi] = deb_q;
    end
  endgenerate

  // ---------------- CPU-visible registers ----------------
  logic [PORT_W-1:0] out0_q, out0_d, out1_q, out1_d;
  logic [DISP_W-1:0] disp_q, disp_d;
  logic              wr_out0, wr_out1, wr_disp;

  assign wr_out0 = we && (addr[7:2] == ADDR_OUT0[7:2]);
  assign wr_out1 = we && (addr[7:2] == ADDR_OUT1[7:2]);
  assign wr_disp = we && (addr[7:2] == ADDR_DISP[7:2]);

  always_comb begin
    out0_d = wr_out0 ? wdata[PORT_W-1:0] : out0_q;
    out1_d = wr_out1 ? wdata[PORT_W-1:0] : out1_q;
    disp_d = wr_disp ? wdata[DISP_W-1:0] : disp_q;
  end

  always_comb begin
    rdata = '0;
    case (addr[7:2])
      ADDR_OUT0[7:2]: rdata = 32'(out0_q);
      ADDR_OUT1[7:2]: rdata = 32'(out1_q);
      ADDR_DISP[7:2]: rdata = 32'(disp_q);
      ADDR_STAT[7:2]: rdata = {31'b0, disp_busy};
      ADDR_IN0[7:2]:  rdata = 32'(in_deb[0]);
      ADDR_IN1[7:2]:  rdata = 32'(in_deb[1]);
      default:        rdata = '0;
    endcase
  end

  // ---------------- display FSM ----------------
  disp_state_e       state_q, state_d;
  logic              pending_q, pending_d;
  logic              sat_q, sat_d;
  logic [5:0][6:0]   hex_q, hex_d, hex_new;
  logic              conv_start, conv_busy, conv_done;
  logic [23:0]       conv_bcd;

  bin2bcd_seq #(.DISP_W(DISP_W)) u_bin2bcd (
    .clock  (clock),
    .resetn (resetn),
    .start  (conv_start),
    .value  (disp_q),
    .busy   (conv_busy),
    .done   (conv_done),
    .bcd    (conv_bcd)
  );

  // Segment image of the finished conversion, with leading zeros blanked
  // from the top down; digit 0 is always shown.
  always_comb begin
    logic       seen;
    logic [3:0] digit;
    seen    = 1'b0;
    digit   = '0;
    hex_new = '0;
    for (int i = 5; i >= 0; i--) begin
      digit = conv_bcd[4*i +: 4];
      if ((digit != 4'd0) || (i == 0)) seen = 1'b1;
      hex_new[i] = seen ? bcd_to_seg(digit) : SEG_BLANK;
    end
    if (sat_q) hex_new = {6{SEG_DASH}};
  end

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    sat_d      = sat_q;
    hex_d      = hex_q;
    conv_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pending_q) begin
          conv_start = 1'b1;
          pending_d  = 1'b0;
          sat_d      = 64'(disp_q) > DISP_MAX;
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (conv_done) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        // The finished (possibly stale) result is always published first;
        // a newer value then restarts the converter straight away.
        hex_d = hex_new;
        if (pending_q) begin
          conv_start = 1'b1;
          pending_d  = 1'b0;
          sat_d      = 64'(disp_q) > DISP_MAX;
          state_d    = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A write landing on the same edge as a restart must not be lost.
    if (wr_disp) pending_d = 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out0_q    <= '0;
      out1_q    <= '0;
      disp_q    <= '0;
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      sat_q     <= 1'b0;
      hex_q     <= {{5{SEG_BLANK}}, SEG_ZERO};
    end else begin
      out0_q    <= out0_d;
      out1_q    <= out1_d;
      disp_q    <= disp_d;
      state_q   <= state_d;
      pending_q <= pending_d;
      sat_q     <= sat_d;
      hex_q     <= hex_d;
    end
  end

  assign out_port0 = out0_q;
  assign out_port1 = out1_q;
  assign disp_busy = (state_q != ST_IDLE);
  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign hex4 = hex_q[4];
  assign hex5 = hex_q[5];

  // Address bits outside the word decode, upper store data and the
  // converter's own busy flag are intentionally not consumed.
  logic unused_bits;
  assign unused_bits = ^{addr[31:8], addr[1:0], wdata, conv_busy};

endmodule
